// File: rtl/pwm_pkg.sv
// pwm_pkg: shared channel function codes and default widths for the PWM core.
package pwm_pkg;
  typedef enum logic [1:0] {
    FN_LEFT  = 2'b00,
    FN_RIGHT = 2'b01,
    FN_RANGE = 2'b10,
    FN_RSVD  = 2'b11
  } pwm_fn_e;
  localparam int CNT_W_DEF   = 16;
  localparam int PRESC_W_DEF = 8;
endpackage

// File: rtl/pwm_channel.sv
// pwm_channel: active compare/function/polarity registers, compare logic and registered output.
module pwm_channel
  import pwm_pkg::*;
#(
  parameter int CNT_W = CNT_W_DEF
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load,
  input  logic             en,
  input  logic [CNT_W-1:0] cnt,
  input  logic [CNT_W-1:0] cmp1_s,
  input  logic [CNT_W-1:0] cmp2_s,
  input  logic [1:0]       func_s,
  input  logic             pol_s,
  output logic             pwm
);
  logic [CNT_W-1:0] cmp1, cmp2;
  pwm_fn_e          func;
  logic             pol, raw;
  always_comb
    raw = func == FN_LEFT  ? cnt < cmp1 :
          func == FN_RIGHT ? cnt >= cmp1 :
          func == FN_RANGE ? (cmp1 <= cnt) && (cnt < cmp2) : 1'b0;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      cmp1 <= '0;
      cmp2 <= '0;
      func <= FN_LEFT;
      pol  <= 1'b0;
      pwm  <= 1'b0;
    end else begin
      if (load) begin
        cmp1 <= cmp1_s;
        cmp2 <= cmp2_s;
        func <= pwm_fn_e'(func_s);
        pol  <= pol_s;
      end
      pwm <= en ? raw ^ pol : pol;
    end
endmodule

// File: rtl/pwm_multi_gen.sv
// pwm_multi_gen: prescaled up/down/center timebase with shadowed config feeding N_CH compare channels.
module pwm_multi_gen
  import pwm_pkg::*;
#(
  parameter int CNT_W   = CNT_W_DEF,
  parameter int N_CH    = 4,
  parameter int PRESC_W = PRESC_W_DEF
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  cnt_en,
  input  logic                  cnt_clr,
  input  logic                  up_notdown,
  input  logic                  center_mode,
  input  logic [CNT_W-1:0]      period,
  input  logic [PRESC_W-1:0]    prescale,
  input  logic [N_CH*CNT_W-1:0] ch_cmp1,
  input  logic [N_CH*CNT_W-1:0] ch_cmp2,
  input  logic [N_CH*2-1:0]     ch_func,
  input  logic [N_CH-1:0]       ch_pol,
  input  logic [N_CH-1:0]       ch_en,
  input  logic                  upd_req,
  output logic                  upd_pending,
  output logic                  period_evt,
  output logic [CNT_W-1:0]      count_val,
  output logic [N_CH-1:0]       pwm_out
);
  logic [PRESC_W-1:0] presc;
  logic [CNT_W-1:0]   cnt, act_p, p_use, nxt, clr_val;
  logic               dir_up, nxt_dir, tick, bnd, apply, down;
  assign count_val = cnt;
  always_comb begin
    down    = !center_mode && !up_notdown;
    tick    = cnt_en && presc >= prescale;
    bnd     = tick && (center_mode || down ? cnt == '0 : cnt >= act_p);
    apply   = (upd_pending && (bnd || !cnt_en || cnt_clr)) || (upd_req && bnd);
    // The new period takes effect for the count following the boundary it is applied on.
    p_use   = apply ? period : act_p;
    clr_val = down ? p_use : '0;
    nxt     = center_mode ? (p_use == '0 ? '0 :
                             dir_up ? (cnt >= p_use ? cnt - 1'b1 : cnt + 1'b1) :
                             (cnt == '0 ? CNT_W'(1) : cnt - 1'b1)) :
              down ? (cnt == '0 ? p_use : cnt - 1'b1) :
              (cnt >= act_p ? '0 : cnt + 1'b1);
    nxt_dir = !center_mode ? dir_up : nxt >= p_use ? 1'b0 : nxt == '0 ? 1'b1 : dir_up;
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      presc       <= '0;
      cnt         <= '0;
      dir_up      <= 1'b1;
      act_p       <= '0;
      upd_pending <= 1'b0;
      period_evt  <= 1'b0;
    end else begin
      period_evt  <= bnd && !cnt_clr;
      upd_pending <= apply ? 1'b0 : upd_pending | upd_req;
      if (apply) act_p <= period;
      if (cnt_clr) begin
        presc  <= '0;
        cnt    <= clr_val;
        dir_up <= 1'b1;
      end else if (cnt_en) begin
        presc <= tick ? '0 : presc + 1'b1;
        if (tick) begin
          cnt    <= nxt;
          dir_up <= nxt_dir;
        end
      end
    end
  for (genvar i = 0; i < N_CH; i++) begin : g_ch
    pwm_channel #(.CNT_W(CNT_W)) u_ch (
      .clk   (clk),
      .rst_n (rst_n),
      .load  (apply),
      .en    (ch_en[i]),
      .cnt   (cnt),
      .cmp1_s(ch_cmp1[i*CNT_W +: CNT_W]),
      .cmp2_s(ch_cmp2[i*CNT_W +: CNT_W]),
      .func_s(ch_func[i*2 +: 2]),
      .pol_s (ch_pol[i]),
      .pwm   (pwm_out[i])
    );
  end
endmodule
